// File: rtl/decoder_2_4_if.sv
// decoder_2_4_if
//   Bundles the decode request (enable + encoded value) and the decoded
//   response (four enable lines + valid) of the 2-to-4 decoder.
//   Modports:
//     master : the select logic drives Enable_In/Encoded_Value_In and
//              observes Data_n_Out/Valid_Out
//     slave  : the decoder samples the request and drives the lines
interface decoder_2_4_if;
  logic       Enable_In;
  logic [1:0] Encoded_Value_In;
  logic       Data_0_Out;
  logic       Data_1_Out;
  logic       Data_2_Out;
  logic       Data_3_Out;
  logic       Valid_Out;

  modport master (
    output Enable_In,
    output Encoded_Value_In,
    input  Data_0_Out,
    input  Data_1_Out,
    input  Data_2_Out,
    input  Data_3_Out,
    input  Valid_Out
  );

  modport slave (
    input  Enable_In,
    input  Encoded_Value_In,
    output Data_0_Out,
    output Data_1_Out,
    output Data_2_Out,
    output Data_3_Out,
    output Valid_Out
  );
endinterface

// File: rtl/decoder_2_4.sv
// decoder_2_4
//   Registered 2-to-4 line decoder. A 2-bit encoded value selects one of
//   four one-hot enable lines. The lines are registered, so they are
//   glitch-free and follow the input with one cycle of latency.
//   Ports:
//     Clock_In : system clock, rising edge
//     Reset_In : synchronous, active-high reset (clears lines and valid)
//     bus      : decoder_2_4_if.slave
//                Enable_In, Encoded_Value_In in;
//                Data_0..3_Out, Valid_Out out
//   Parameter:
//     OUT_ACTIVE_LOW : 0 = selected line is 1, 1 = selected line is 0
//   Build option:
//     DECODER_2_4_HOLD_EN : when defined, Enable_In=0 holds the last decode
//                           and valid instead of clearing them
module decoder_2_4 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input logic           Clock_In,
  input logic           Reset_In,
  decoder_2_4_if.slave  bus
);

  logic [3:0] dec_q;
  logic       valid_q;

  // Reset wins over everything, so an undefined select during reset is
  // never loaded into dec_q.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      dec_q   <= 4'b0000;
      valid_q <= 1'b0;
    end else if (bus.Enable_In) begin
      dec_q   <= 4'b0001 << bus.Encoded_Value_In;
      valid_q <= 1'b1;
    end
`ifdef DECODER_2_4_HOLD_EN
    // Enable low: keep the previous decode and valid.
`else
    else begin
      dec_q   <= 4'b0000;
      valid_q <= 1'b0;
    end
`endif
  end

  // Polarity is applied after the register; an XOR with a constant adds no
  // state and keeps the one-hot register itself polarity-independent.
  assign bus.Data_0_Out = dec_q[0] ^ OUT_ACTIVE_LOW;
  assign bus.Data_1_Out = dec_q[1] ^ OUT_ACTIVE_LOW;
  assign bus.Data_2_Out = dec_q[2] ^ OUT_ACTIVE_LOW;
  assign bus.Data_3_Out = dec_q[3] ^ OUT_ACTIVE_LOW;
  assign bus.Valid_Out  = valid_q;

endmodule

// File: tb/tb_decoder_2_4.sv
// tb_decoder_2_4
//   Directed bench for decoder_2_4. Two instances share the stimulus: one
//   with active-high lines, one with active-low lines. Expected values are
//   written by hand as the active-high one-hot pattern; the active-low
//   expectation is its complement on the data lines.
module tb_decoder_2_4;

  logic Clock_In;
  logic Reset_In;

  decoder_2_4_if bus_hi ();
  decoder_2_4_if bus_lo ();

  decoder_2_4 #(.OUT_ACTIVE_LOW(1'b0)) u_dut_hi (
    .Clock_In (Clock_In),
    .Reset_In (Reset_In),
    .bus      (bus_hi.slave)
  );

  decoder_2_4 #(.OUT_ACTIVE_LOW(1'b1)) u_dut_lo (
    .Clock_In (Clock_In),
    .Reset_In (Reset_In),
    .bus      (bus_lo.slave)
  );

  initial Clock_In = 1'b0;
  always #5 Clock_In = ~Clock_In;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Checks both instances against an active-high expectation {valid, d3..d0}.
  task automatic check_both(input string tag, input logic valid, input logic [3:0] dec);
    check({tag, "_hi"},
          {bus_hi.Valid_Out, bus_hi.Data_3_Out, bus_hi.Data_2_Out,
           bus_hi.Data_1_Out, bus_hi.Data_0_Out},
          {valid, dec});
    check({tag, "_lo"},
          {bus_lo.Valid_Out, bus_lo.Data_3_Out, bus_lo.Data_2_Out,
           bus_lo.Data_1_Out, bus_lo.Data_0_Out},
          {valid, ~dec});
  endtask

  task automatic drive(input logic rst, input logic en, input logic [1:0] val);
    Reset_In                = rst;
    bus_hi.Enable_In        = en;
    bus_hi.Encoded_Value_In = val;
    bus_lo.Enable_In        = en;
    bus_lo.Encoded_Value_In = val;
  endtask

  // Apply inputs, take one rising edge, sample on the following falling edge.
  task automatic step(input logic rst, input logic en, input logic [1:0] val);
    drive(rst, en, val);
    @(posedge Clock_In);
    @(negedge Clock_In);
  endtask

  initial begin
    logic [1:0] sweep_val [4]  = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [3:0] sweep_exp [4]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [1:0] rand_val  [10] = '{2'd3, 2'd0, 2'd2, 2'd2, 2'd1,
                                   2'd0, 2'd3, 2'd1, 2'd2, 2'd0};
    logic [3:0] rand_exp  [10] = '{4'b1000, 4'b0001, 4'b0100, 4'b0100, 4'b0010,
                                   4'b0001, 4'b1000, 4'b0010, 4'b0100, 4'b0001};
    int ones;

    // Reset held for two edges with an undefined select and enable high.
    step(1'b1, 1'b1, 2'bxx);
    check_both("reset_edge1", 1'b0, 4'b0000);
    step(1'b1, 1'b1, 2'bxx);
    check_both("reset_edge2", 1'b0, 4'b0000);

    // Exhaustive sweep, back-to-back, one-cycle latency.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, sweep_val[i]);
      check_both($sformatf("sweep_%0d", i), 1'b1, sweep_exp[i]);
    end

    // Fixed pseudo-random stream, one value per cycle.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, rand_val[i]);
      check_both($sformatf("stream_%0d", i), 1'b1, rand_exp[i]);
      ones = $countones({bus_hi.Data_3_Out, bus_hi.Data_2_Out,
                         bus_hi.Data_1_Out, bus_hi.Data_0_Out});
      check($sformatf("onehot_%0d", i), 5'(ones), 5'd1);
    end

    // Enable low after a decode of 2.
    step(1'b0, 1'b1, 2'd2);
    check_both("enable_pre", 1'b1, 4'b0100);
    step(1'b0, 1'b0, 2'd3);
`ifdef DECODER_2_4_HOLD_EN
    check_both("enable_low", 1'b1, 4'b0100);
`else
    check_both("enable_low", 1'b0, 4'b0000);
`endif

    // Mid-stream reset, then release straight into a decode.
    step(1'b0, 1'b1, 2'd1);
    check_both("mid_pre", 1'b1, 4'b0010);
    step(1'b1, 1'b1, 2'd3);
    check_both("mid_reset", 1'b0, 4'b0000);
    step(1'b0, 1'b1, 2'd3);
    check_both("mid_release", 1'b1, 4'b1000);

    // Repeated identical input keeps the same line active.
    step(1'b0, 1'b1, 2'd3);
    check_both("repeat_1", 1'b1, 4'b1000);
    step(1'b0, 1'b1, 2'd3);
    check_both("repeat_2", 1'b1, 4'b1000);

    // Reset pulsed between edges must not affect the outputs.
    step(1'b0, 1'b1, 2'd2);
    check_both("sync_pre", 1'b1, 4'b0100);
    Reset_In = 1'b1;
    #2;
    Reset_In = 1'b0;
    #1;
    check_both("sync_between", 1'b1, 4'b0100);
    step(1'b0, 1'b1, 2'd2);
    check_both("sync_after", 1'b1, 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/decoder_2_4.md
Name: decoder_2_4

Overview:
- Registered 2-to-4 line decoder: a 2-bit encoded value selects exactly one of four one-hot output lines.
- Sits between control/select logic and downstream enable lines (chip selects, mux enables).
- Outputs are registered on the single clock, giving one cycle of latency and glitch-free outputs.
- Synchronous reset forces every output line inactive.

Parameters:
- OUT_ACTIVE_LOW, default 0, output polarity.
  - 0: the selected line is driven 1 and the others 0.
  - 1: the selected line is driven 0 and the others 1. Inactive level is 1.

Ports:
- Clock_In  input  1  system clock; all state updates on the rising edge.
- Reset_In  input  1  synchronous, active-high reset.
- Enable_In  input  1  decode enable; when 1, the input is decoded at the next edge.
- Encoded_Value_In  input  2  encoded select value, 0..3.
- Data_0_Out  output  1  active when the registered decode of Encoded_Value_In is 0.
- Data_1_Out  output  1  active when the registered decode is 1.
- Data_2_Out  output  1  active when the registered decode is 2.
- Data_3_Out  output  1  active when the registered decode is 3.
- Valid_Out  output  1  1 when a decode was registered on the last edge (Enable_In was 1 and Reset_In was 0).

Behaviour:
- The block holds one 4-bit one-hot register, dec_q, plus a valid flag.
  - Output polarity is applied combinationally after dec_q: Data_n_Out = dec_q[n] XOR OUT_ACTIVE_LOW.
- Reset:
  - On a rising edge with Reset_In=1, dec_q=4'b0000 and Valid_Out=0.
  - All Data outputs then sit at the inactive level: 0 when OUT_ACTIVE_LOW=0, 1 when OUT_ACTIVE_LOW=1.
  - Reset has priority over Enable_In and Encoded_Value_In.
  - An X or undefined Encoded_Value_In during reset must not reach the outputs.
  - Reset is synchronous only: asserting it between edges has no effect until the next rising edge.
- Decode, on a rising edge with Reset_In=0 and Enable_In=1:
  - dec_q = 4'b0001 << Encoded_Value_In, and Valid_Out=1.
  - Mapping: 0 -> Data_0 active, 1 -> Data_1, 2 -> Data_2, 3 -> Data_3.
- Latency:
  - A value present before edge k appears on the outputs immediately after edge k (one cycle).
  - Back-to-back values decode every cycle at full throughput, with no bubbles.
- Idle, on a rising edge with Reset_In=0 and Enable_In=0:
  - dec_q=4'b0000, all outputs go inactive, and Valid_Out=0.
- Invariant: at most one Data output is active in any cycle, and exactly one whenever Valid_Out=1.
- Reset mid-stream: the next edge clears the outputs regardless of input. Decoding resumes on the first edge after Reset_In returns to 0 with Enable_In=1, with no extra delay cycle.
- Repeated identical inputs keep the same line active continuously, with no toggle.

Optional Feature:
- Macro: DECODER_2_4_HOLD_EN.
- Defined: when Enable_In=0 (and Reset_In=0), dec_q and Valid_Out hold their previous values instead of clearing. Reset still clears both.
- Undefined: default idle behaviour as above, i.e. outputs inactive and Valid_Out=0 while Enable_In=0.

Test Plan:
- Reset: Reset_In=1 for 2 edges with Encoded_Value_In=X, Enable_In=1 -> Data_0..3_Out=0000, Valid_Out=0. With OUT_ACTIVE_LOW=1 -> 1111.
- Exhaustive sweep:
  - Stimulus: Reset_In=0, Enable_In=1, input 0,1,2,3 on consecutive edges.
  - Response: after each edge {Data_3..Data_0} = 0001, 0010, 0100, 1000; Valid_Out=1; one-cycle latency.
- Random stream: 10 random 2-bit values, one per cycle -> output matches 1<<previous-cycle input, exactly one line high per cycle.
- Enable low: input 2 decoded, then Enable_In=0 with input 3.
  - Without DECODER_2_4_HOLD_EN -> outputs 0000, Valid_Out=0.
  - With it -> outputs stay 0100, Valid_Out=1.
- Mid-stream reset: input 1 decoded (0010), then Reset_In=1 for one edge with input 3 -> 0000, Valid_Out=0. Release with input 3 -> 1000 on the next edge.
- Polarity: OUT_ACTIVE_LOW=1, input 1 -> outputs 1101, Valid_Out=1.
